// File: rtl/qif_spike_monitor_if.sv
// ISI readout channel between the spike monitor and the host/readout logic.
// Latency: none (bundle of wires); isi_data is the FIFO head, the rest are registered.
// Backpressure: consumer holds isi_ready low; the producer keeps isi_data stable while isi_valid.
// Signals:
//   isi_data   producer -> consumer  ISI value at the FIFO head (0 when empty)
//   isi_valid  producer -> consumer  FIFO not empty
//   isi_ready  consumer -> producer  head is taken at an edge with isi_valid && isi_ready
//   fifo_full  producer -> consumer  FIFO holds its full number of entries
interface qif_spike_monitor_if #(
  parameter int ISI_W = 16
);
  logic [ISI_W-1:0] isi_data;
  logic             isi_valid;
  logic             isi_ready;
  logic             fifo_full;

  modport master (
    output isi_data,
    output isi_valid,
    output fifo_full,
    input  isi_ready
  );

  modport slave (
    input  isi_data,
    input  isi_valid,
    input  fifo_full,
    output isi_ready
  );
endinterface

// File: rtl/qif_spike_monitor.sv
// Spike detector for the QIF neuron: threshold up-crossing, refractory lockout, ISI measurement, ISI FIFO.
// Latency: spike and the ISI push appear one cycle after the accepting edge; isi_data is the FIFO head read.
// Backpressure: isi_ready low holds the FIFO; a push into a full FIFO without a pop is dropped and counted.
// Ports:
//   clk, rst_n      clock (rising edge) and synchronous active-low reset
//   i_en            sample enable; low freezes detection and ISI counting (FIFO pop still works)
//   i_v_in          signed 8-bit membrane voltage
//   o_spike         one-cycle pulse per accepted spike
//   o_spike_count   accepted spikes since reset, wraps
//   o_drop_count    ISIs lost to a full FIFO, saturates at 255
//   isi_if          ISI readout channel (master side)
module qif_spike_monitor #(
  parameter logic signed [7:0] THRESH     = 8'sd50,
  parameter int                REFRACT    = 3,
  parameter int                ISI_W      = 16,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_en,
  input  logic signed [7:0]         i_v_in,
  output logic                      o_spike,
  output logic [15:0]               o_spike_count,
  output logic [7:0]                o_drop_count,
  qif_spike_monitor_if.master       isi_if
);

  // A zero refractory period still needs a 1-bit counter that simply stays at 0.
  localparam int               RW        = (REFRACT < 1) ? 1 : $clog2(REFRACT + 1);
  localparam logic [RW-1:0]    REFR_LOAD = RW'(REFRACT);
  localparam logic [ISI_W-1:0] ISI_MAX   = '1;
  localparam int               AW        = $clog2(FIFO_DEPTH);
  localparam int               CW        = AW + 1;
  localparam logic [CW-1:0]    CNT_FULL  = CW'(FIFO_DEPTH);

  logic signed [7:0] r_v_prev;
  logic [RW-1:0]     r_refr_cnt;
  logic [ISI_W-1:0]  r_isi_cnt;
  logic              r_armed;
  logic              r_spike;
  logic [15:0]       r_spike_count;
  logic [7:0]        r_drop_count;

  logic [ISI_W-1:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic              w_cross;
  logic              w_accept;
  logic [ISI_W-1:0]  w_isi_next;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push_req;
  logic              w_push;
  logic              w_drop;

  // Signed compares: v_prev below threshold, current sample at or above it.
  assign w_cross    = i_en && (r_v_prev < THRESH) && (i_v_in >= THRESH);
  assign w_accept   = w_cross && (r_refr_cnt == '0);
  assign w_isi_next = (r_isi_cnt == ISI_MAX) ? ISI_MAX : r_isi_cnt + 1'b1;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_FULL);
  assign w_pop      = !w_empty && isi_if.isi_ready;
  // The first accepted spike only arms the ISI measurement.
  assign w_push_req = w_accept && r_armed;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v_prev      <= -8'sd128;
      r_refr_cnt    <= '0;
      r_isi_cnt     <= '0;
      r_armed       <= 1'b0;
      r_spike       <= 1'b0;
      r_spike_count <= '0;
      r_drop_count  <= '0;
    end else begin
      r_spike <= w_accept;
      if (i_en) begin
        r_v_prev <= i_v_in;
        if (w_accept) begin
          r_refr_cnt <= REFR_LOAD;
        end else if (r_refr_cnt != '0) begin
          r_refr_cnt <= r_refr_cnt - 1'b1;
        end
        r_isi_cnt <= w_accept ? '0 : w_isi_next;
      end
      if (w_accept) begin
        r_armed       <= 1'b1;
        r_spike_count <= r_spike_count + 16'd1;
      end
      if (w_drop && (r_drop_count != 8'hFF)) begin
        r_drop_count <= r_drop_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to 0 whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_isi_next;
  end

  assign o_spike          = r_spike;
  assign o_spike_count    = r_spike_count;
  assign o_drop_count     = r_drop_count;
  assign isi_if.isi_valid = !w_empty;
  assign isi_if.fifo_full = w_full;
  assign isi_if.isi_data  = w_empty ? '0 : r_mem[r_rd_ptr];

endmodule
